// File: rtl/wb_bus_pkg.sv
// Shared types and constants for the Wishbone window decoder/multiplexer.
package wb_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RACK,
        ST_WAIT,
        ST_HACK,
        ST_ERR,
        ST_GAP
    } state_e;

    // Value returned on wb_rdata whenever no acknowledge is being presented.
    localparam int unsigned DEAD_DATA = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_decoder_mux.sv
// Wishbone slave-side decoder/mux: splits the bus into NS address windows, each either a
// RAM-style port (bridge-generated write pulse and ack) or a handshaked slave with watchdog.
module wb_decoder_mux
    import wb_bus_pkg::*;
#(
    parameter int              AW       = 17,
    parameter int              DW       = 32,
    parameter int              NS       = 4,
    parameter int              SEL_LSB  = 13,
    parameter logic [NS-1:0]   RAM_MASK = 'b1100,
    parameter int              TMO      = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      wb_addr,
    input  logic [DW-1:0]      wb_wdata,
    input  logic [DW/8-1:0]    wb_wstb,
    input  logic               wb_we,
    input  logic               wb_cyc,
    input  logic               wb_stb,
    output logic [DW-1:0]      wb_rdata,
    output logic               wb_ack,
    output logic               wb_err,
    output logic [AW-3:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    output logic [DW/8-1:0]    s_wstb,
    output logic               s_we,
    output logic [NS-1:0]      s_cyc,
    output logic [NS-1:0]      s_wpulse,
    input  logic [NS*DW-1:0]   s_rdata,
    input  logic [NS-1:0]      s_ack,
    output logic               busy
);

    localparam int          SW    = clog2(NS);
    localparam logic [SW:0] NS_W  = (SW+1)'(NS);
    localparam logic [7:0]  TMO_W = 8'(TMO);

    state_e          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [7:0]      timer_q, timer_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [NS-1:0]   cyc_q, cyc_d;
    logic [NS-1:0]   wpulse_q, wpulse_d;

    logic            req;
    logic [SW-1:0]   sel_in;
    logic            sel_ok;
    logic [NS-1:0]   sel_onehot;
    logic [DW-1:0]   slv_rdata [NS];
    logic            unused_addr_lsb;

    assign req        = wb_cyc & wb_stb;
    assign sel_in     = wb_addr[SEL_LSB +: SW];
    assign sel_ok     = ({1'b0, sel_in} < NS_W);
    assign sel_onehot = {{(NS-1){1'b0}}, 1'b1} << sel_in;
    assign unused_addr_lsb = ^wb_addr[1:0];

    for (genvar gi = 0; gi < NS; gi++) begin : g_rdata
        assign slv_rdata[gi] = s_rdata[gi*DW +: DW];
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        timer_d  = timer_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = DW'(DEAD_DATA);
        cyc_d    = cyc_q;
        wpulse_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    sel_d = sel_in;
                    if (!sel_ok) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (RAM_MASK[sel_in]) begin
                        state_d  = ST_RACK;
                        ack_d    = 1'b1;
                        rdata_d  = slv_rdata[sel_in];
                        wpulse_d = wb_we ? sel_onehot : '0;
                    end else begin
                        state_d = ST_WAIT;
                        cyc_d   = sel_onehot;
                        timer_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                // Abort beats ack, and ack beats the watchdog when they coincide.
                if (!req) begin
                    cyc_d   = '0;
                    state_d = ST_GAP;
                end else if (s_ack[sel_q]) begin
                    cyc_d   = '0;
                    state_d = ST_HACK;
                    ack_d   = 1'b1;
                    rdata_d = slv_rdata[sel_q];
                end else if (timer_q == TMO_W) begin
                    cyc_d   = '0;
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + {7'd0, (timer_q != 8'hFF)};
                end
            end
            ST_RACK, ST_HACK, ST_ERR: state_d = ST_GAP;
            ST_GAP:                   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            timer_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cyc_q    <= '0;
            wpulse_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            timer_q  <= timer_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cyc_q    <= cyc_d;
            wpulse_q <= wpulse_d;
        end
    end

    assign s_addr   = wb_addr[AW-1:2];
    assign s_wdata  = wb_wdata;
    assign s_wstb   = wb_wstb;
    assign s_we     = wb_we;
    assign wb_rdata = rdata_q;
    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign s_cyc    = cyc_q;
    assign s_wpulse = wpulse_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_decoder_mux.sv
// Scoreboard bench for wb_decoder_mux: stimulus pushes expected responses, a negedge monitor
// pops and compares them against every wb_ack/wb_err the DUT presents.
module tb_wb_decoder_mux;

    localparam int AW = 17, DW = 32, NS = 4, SEL_LSB = 13, TMO = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     wb_addr = '0;
    logic [DW-1:0]     wb_wdata = '0;
    logic [DW/8-1:0]   wb_wstb = '0;
    logic              wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [DW-1:0]     wb_rdata;
    logic              wb_ack, wb_err;
    logic [AW-3:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstb;
    logic              s_we;
    logic [NS-1:0]     s_cyc, s_wpulse;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS-1:0]     s_ack = '0;
    logic              busy;

    wb_decoder_mux #(
        .AW(AW), .DW(DW), .NS(NS), .SEL_LSB(SEL_LSB), .RAM_MASK(4'b1100), .TMO(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wstb(wb_wstb), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_rdata(wb_rdata), .wb_ack(wb_ack), .wb_err(wb_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstb(s_wstb), .s_we(s_we),
        .s_cyc(s_cyc), .s_wpulse(s_wpulse), .s_rdata(s_rdata), .s_ack(s_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: every response must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
                e = sb.pop_front();
                check("resp_missing", 1'b0, 1'b1);
            end
            check("ack_err_excl", {63'd0, wb_ack & wb_err}, 64'd0);
            check("onehot0", {62'd0, $onehot0(s_cyc), $onehot0(s_wpulse)}, 64'd3);
            if (wb_ack || wb_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {62'd0, wb_ack, wb_err}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_kind", {62'd0, wb_ack, wb_err}, e.is_err ? 64'd1 : 64'd2);
                    check("resp_rdata", wb_rdata, e.rdata);
                    check("resp_cycle", cyc_cnt, e.cyc);
                end
            end else begin
                check("rdata_idle", wb_rdata, 64'd0);
            end
        end
    end

    task automatic idle_bus();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic drive_req(input logic [AW-1:0] a, input logic we,
                             input logic [31:0] d, input logic [3:0] st);
        @(posedge clk); #1;
        wb_addr  = a;
        wb_we    = we;
        wb_wdata = d;
        wb_wstb  = st;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
    endtask

    // RAM window access; hold keeps the request asserted through the GAP cycle.
    task automatic ram_txn(input int sel, input logic [AW-1:0] a, input logic we,
                           input logic [31:0] d, input logic [3:0] st,
                           input logic [31:0] rd_exp, input bit hold);
        int t0;
        drive_req(a, we, d, st);
        t0 = cyc_cnt;
        sb.push_back('{1'b0, rd_exp, t0 + 1});
        @(negedge clk);
        check("s_addr", s_addr, a[AW-1:2]);
        check("s_wdata", s_wdata, d);
        check("s_wstb", s_wstb, st);
        check("s_we", s_we, we);
        check("wpulse_req", s_wpulse, 0);
        @(negedge clk);
        check("wpulse_rack", s_wpulse, we ? (64'd1 << sel) : 64'd0);
        check("busy_rack", busy, 1);
        @(posedge clk); #1;
        if (!hold) idle_bus();
        @(negedge clk);
        check("wpulse_gap", s_wpulse, 0);
        check("busy_gap", busy, 1);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check("busy_idle", busy, 0);
    endtask

    // Handshaked window read; the slave acks dly cycles into WAIT.
    task automatic hs_txn(input int sel, input logic [AW-1:0] a, input int dly,
                          input logic [31:0] d);
        int t0;
        drive_req(a, 1'b0, 32'd0, 4'hF);
        t0 = cyc_cnt;
        sb.push_back('{1'b0, d, t0 + dly + 1});
        for (int k = 1; k <= dly; k++) begin
            @(posedge clk); #1;
            if (k == dly) begin
                s_rdata[sel*DW +: DW] = d;
                s_ack[sel] = 1'b1;
            end
            @(negedge clk);
            check("s_cyc_wait", s_cyc, 64'd1 << sel);
        end
        @(posedge clk); #1;
        s_ack = '0;
        @(negedge clk);
        check("s_cyc_hack", s_cyc, 0);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check("busy_gap", busy, 1);
        @(negedge clk);
        check("busy_idle", busy, 0);
    endtask

    initial begin : stim
        int t0;
        for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = 32'hD0D0_0000 + i;

        repeat (2) @(negedge clk);
        check("rst_ack", wb_ack, 0);
        check("rst_err", wb_err, 0);
        check("rst_rdata", wb_rdata, 0);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_wpulse", s_wpulse, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // RAM write to window 3; read data of window 3 comes back with the ack.
        ram_txn(3, 17'h06010, 1'b1, 32'hA5A5_5A5A, 4'hF, 32'hD0D0_0003, 1'b0);
        check("s_addr_6010", 64'(17'h06010 >> 2), 64'h1804);

        // RAM read from window 2, request held through GAP must not re-ack.
        s_rdata[2*DW +: DW] = 32'h1234_5678;
        ram_txn(2, 17'h04020, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b1);
        // Partial-strobe RAM write to window 2.
        ram_txn(2, 17'h05FFC, 1'b1, 32'h0BAD_F00D, 4'h3, 32'h1234_5678, 1'b0);

        // Handshaked read on window 0 with a five-cycle slave, then a fast one on window 1.
        hs_txn(0, 17'h00100, 5, 32'h0000_BEEF);
        hs_txn(1, 17'h03FF8, 1, 32'hCAFE_0001);

        // Window 1 never acks; stray acks on other windows are ignored.
        drive_req(17'h02000, 1'b0, 32'd0, 4'hF);
        t0 = cyc_cnt;
        sb.push_back('{1'b1, 32'd0, t0 + TMO + 2});
        for (int k = 1; k <= TMO + 1; k++) begin
            @(posedge clk); #1;
            s_ack = (k == 3) ? 4'b0001 : ((k == 4) ? 4'b1000 : 4'b0000);
            @(negedge clk);
            check("s_cyc_tmo", s_cyc, 4'b0010);
        end
        @(posedge clk); #1;
        s_ack = '0;
        @(negedge clk);
        check("s_cyc_err", s_cyc, 0);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check("busy_err_gap", busy, 1);
        @(negedge clk);
        check("busy_err_idle", busy, 0);

        // Master abort three cycles into WAIT, followed by a late slave ack.
        drive_req(17'h00100, 1'b0, 32'd0, 4'hF);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("s_cyc_abort_wait", s_cyc, 4'b0001);
        end
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check("s_cyc_abort_drop", s_cyc, 4'b0001);
        @(posedge clk); #1;
        s_ack = 4'b0001;
        @(negedge clk);
        check("s_cyc_abort_gap", s_cyc, 0);
        check("busy_abort_gap", busy, 1);
        @(posedge clk); #1;
        s_ack = '0;
        @(negedge clk);
        check("busy_abort_idle", busy, 0);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of WAIT.
        drive_req(17'h00100, 1'b0, 32'd0, 4'hF);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("s_cyc_prerst", s_cyc, 4'b0001);
        end
        rst_n = 1'b0;
        #1;
        check("async_s_cyc", s_cyc, 0);
        check("async_ack", wb_ack, 0);
        check("async_busy", busy, 0);
        idle_bus();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        s_rdata[3*DW +: DW] = 32'h7777_8888;
        ram_txn(3, 17'h07FFC, 1'b0, 32'h0, 4'hF, 32'h7777_8888, 1'b0);
        hs_txn(0, 17'h00004, 2, 32'h5555_AAAA);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
